// File: rtl/huc_pkg.sv
// Shared types for the cartridge memory channel: the mapper request bundle,
// the memory-responder state encoding and its data-out reset value.
package huc_pkg;

   typedef struct packed {
      logic [22:0] addr;
      logic [7:0]  dati;
      logic        ce;
      logic        ce2;
      logic        oe;
      logic        we;
   } MemCtrl;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      REC  = 2'd3
   } HucMemSt;

   localparam logic [7:0] HUC_MEM_DATO_RST = 8'hFF;

endpackage

// File: rtl/huc_mem_cache.sv
// One-word read cache for huc_mem_ctrl (used when HUC_MEM_RDCACHE_EN is
// defined): tag = byte address bits [22:1], 16-bit word, valid bit.
// Filled at the end of every external read; byte-updated by writes that
// land on the cached word so it never goes stale.
module huc_mem_cache (
   input  logic        clk,
   input  logic        rst,
   input  logic [21:0] i_lkp_tag,
   input  logic        i_fill_en,
   input  logic [21:0] i_fill_tag,
   input  logic [15:0] i_fill_data,
   input  logic        i_upd_en,
   input  logic [22:0] i_upd_addr,
   input  logic [7:0]  i_upd_data,
   output logic        o_hit,
   output logic [15:0] o_data
);

   logic        r_valid;
   logic [21:0] r_tag;
   logic [15:0] r_data;

   assign o_hit  = r_valid & (r_tag == i_lkp_tag);
   assign o_data = r_data;

   // tag/data store: fill replaces the word, a write patches one byte on a tag match
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_data  <= '0;
      end else if (i_fill_en) begin
         r_valid <= 1'b1;
         r_tag   <= i_fill_tag;
         r_data  <= i_fill_data;
      end else if (i_upd_en && r_valid && (r_tag == i_upd_addr[22:1])) begin
         if (i_upd_addr[0]) r_data[15:8] <= i_upd_data;
         else               r_data[7:0]  <= i_upd_data;
      end
   end

endmodule

// File: rtl/huc_mem_ctrl.sv
// Memory-side responder for the mapper MemCtrl channel. Turns level-style
// ce/oe/we requests into timed cycles on an async 16-bit SRAM/PSRAM and
// returns byte read data on dato. Optional read cache: HUC_MEM_RDCACHE_EN.
//
// state | meaning
// IDLE  | no access; pending write served first, then read
// RD    | strobes low, byte sampled into dato on the last cycle
// WR    | mem_we_n low with captured byte on both bus halves
// REC   | strobes high, bus still driven for one recovery clock
module huc_mem_ctrl
   import huc_pkg::*;
#(
   parameter int RD_CYC = 4,
   parameter int WR_CYC = 4,
   parameter int ADDR_W = 22
) (
   input  logic              clk,
   input  logic              rst,
   input  MemCtrl            req,
   output logic [7:0]        dato,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_dq_o,
   input  logic [15:0]       mem_dq_i,
   output logic              mem_dq_oe,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              mem_ub_n,
   output logic              mem_lb_n
);

   MemCtrl            r_req;
   logic              r_rd_lvl_d;
   logic [22:0]       r_addr_d;
   HucMemSt           r_state, w_state_n;
   logic [3:0]        r_cnt, w_cnt_n;
   logic              r_wp_valid, w_wp_valid_n;
   logic [22:0]       r_wp_addr, w_wp_addr_n;
   logic [7:0]        r_wp_data, w_wp_data_n;
   logic              r_rd_pend, w_rd_pend_n;
   logic              r_lane, w_lane_n;
   logic [7:0]        w_dato_n;
   logic [ADDR_W-1:0] w_addr_n;
   logic [15:0]       w_dq_o_n;
   logic              w_dq_oe_n, w_ce_n_n, w_oe_n_n, w_we_n_n, w_ub_n_n, w_lb_n_n;
   logic              w_act, w_rd_lvl, w_rd_trig, w_wr_trig, w_wr_go;
   logic [22:0]       w_wa;
   logic [7:0]        w_wd;
   logic              w_hit;
   logic [15:0]       w_cdata;

   assign w_act     = r_req.ce & r_req.ce2;
   assign w_rd_lvl  = w_act & r_req.oe;
   assign w_rd_trig = w_rd_lvl & (~r_rd_lvl_d | (r_req.addr != r_addr_d));
   assign w_wr_trig = w_act & r_req.we;
   // an already-pending write is older than one arriving now, so it goes first
   assign w_wr_go   = (r_state == IDLE) & (r_wp_valid | w_wr_trig);
   assign w_wa      = r_wp_valid ? r_wp_addr : r_req.addr;
   assign w_wd      = r_wp_valid ? r_wp_data : r_req.dati;
   assign busy      = (r_state != IDLE) | r_wp_valid | r_rd_pend;

`ifdef HUC_MEM_RDCACHE_EN
   logic [21:0] r_rd_tag;

   // remember which word the running external read belongs to, for the fill
   always_ff @(posedge clk) begin
      if (rst)                                      r_rd_tag <= '0;
      else if (r_state == IDLE && w_state_n == RD) r_rd_tag <= r_req.addr[22:1];
   end

   huc_mem_cache u_cache (
      .clk         (clk),
      .rst         (rst),
      .i_lkp_tag   (r_req.addr[22:1]),
      .i_fill_en   ((r_state == RD) && (r_cnt == 4'd0)),
      .i_fill_tag  (r_rd_tag),
      .i_fill_data (mem_dq_i),
      .i_upd_en    (w_wr_go),
      .i_upd_addr  (w_wa),
      .i_upd_data  (w_wd),
      .o_hit       (w_hit),
      .o_data      (w_cdata)
   );
`else
   assign w_hit   = 1'b0;
   assign w_cdata = 16'h0000;
`endif

   // next state, pending bookkeeping and next registered bus outputs
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_wp_valid_n = r_wp_valid;
      w_wp_addr_n  = r_wp_addr;
      w_wp_data_n  = r_wp_data;
      w_rd_pend_n  = r_rd_pend | w_rd_trig;
      w_lane_n     = r_lane;
      w_dato_n     = dato;
      w_addr_n     = mem_addr;
      w_dq_o_n     = mem_dq_o;
      w_dq_oe_n    = mem_dq_oe;
      w_ce_n_n     = mem_ce_n;
      w_oe_n_n     = mem_oe_n;
      w_we_n_n     = mem_we_n;
      w_ub_n_n     = mem_ub_n;
      w_lb_n_n     = mem_lb_n;

      // last write wins if the single entry is already occupied
      if (w_wr_trig) begin
         w_wp_valid_n = 1'b1;
         w_wp_addr_n  = r_req.addr;
         w_wp_data_n  = r_req.dati;
      end

      case (r_state)
         IDLE: begin
            if (w_wr_go) begin
               if (!(r_wp_valid && w_wr_trig)) w_wp_valid_n = 1'b0;
               w_state_n = WR;
               w_cnt_n   = 4'(WR_CYC - 1);
               w_addr_n  = w_wa[ADDR_W:1];
               w_dq_o_n  = {w_wd, w_wd};
               w_dq_oe_n = 1'b1;
               w_ce_n_n  = 1'b0;
               w_we_n_n  = 1'b0;
               w_oe_n_n  = 1'b1;
               w_ub_n_n  = ~w_wa[0];
               w_lb_n_n  = w_wa[0];
            end else if (r_rd_pend || w_rd_trig) begin
               w_rd_pend_n = 1'b0;
               if (w_hit) begin
                  w_dato_n = r_req.addr[0] ? w_cdata[15:8] : w_cdata[7:0];
               end else begin
                  w_state_n = RD;
                  w_cnt_n   = 4'(RD_CYC - 1);
                  w_lane_n  = r_req.addr[0];
                  w_addr_n  = r_req.addr[ADDR_W:1];
                  w_ce_n_n  = 1'b0;
                  w_oe_n_n  = 1'b0;
                  w_ub_n_n  = ~r_req.addr[0];
                  w_lb_n_n  = r_req.addr[0];
               end
            end
         end
         RD: begin
            if (r_cnt == 4'd0) begin
               w_state_n = IDLE;
               w_dato_n  = r_lane ? mem_dq_i[15:8] : mem_dq_i[7:0];
               w_ce_n_n  = 1'b1;
               w_oe_n_n  = 1'b1;
               w_ub_n_n  = 1'b1;
               w_lb_n_n  = 1'b1;
            end else begin
               w_cnt_n = r_cnt - 4'd1;
            end
         end
         WR: begin
            if (r_cnt == 4'd0) begin
               w_state_n = REC;
               w_ce_n_n  = 1'b1;
               w_we_n_n  = 1'b1;
               w_ub_n_n  = 1'b1;
               w_lb_n_n  = 1'b1;
            end else begin
               w_cnt_n = r_cnt - 4'd1;
            end
         end
         REC: begin
            w_state_n = IDLE;
            w_dq_oe_n = 1'b0;
         end
         default: w_state_n = IDLE;
      endcase
   end

   // state register, input capture and registered bus outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_req      <= '0;
         r_rd_lvl_d <= 1'b0;
         r_addr_d   <= '0;
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_wp_valid <= 1'b0;
         r_wp_addr  <= '0;
         r_wp_data  <= '0;
         r_rd_pend  <= 1'b0;
         r_lane     <= 1'b0;
         dato       <= HUC_MEM_DATO_RST;
         mem_addr   <= '0;
         mem_dq_o   <= '0;
         mem_dq_oe  <= 1'b0;
         mem_ce_n   <= 1'b1;
         mem_oe_n   <= 1'b1;
         mem_we_n   <= 1'b1;
         mem_ub_n   <= 1'b1;
         mem_lb_n   <= 1'b1;
      end else begin
         r_req      <= req;
         r_rd_lvl_d <= w_rd_lvl;
         r_addr_d   <= r_req.addr;
         r_state    <= w_state_n;
         r_cnt      <= w_cnt_n;
         r_wp_valid <= w_wp_valid_n;
         r_wp_addr  <= w_wp_addr_n;
         r_wp_data  <= w_wp_data_n;
         r_rd_pend  <= w_rd_pend_n;
         r_lane     <= w_lane_n;
         dato       <= w_dato_n;
         mem_addr   <= w_addr_n;
         mem_dq_o   <= w_dq_o_n;
         mem_dq_oe  <= w_dq_oe_n;
         mem_ce_n   <= w_ce_n_n;
         mem_oe_n   <= w_oe_n_n;
         mem_we_n   <= w_we_n_n;
         mem_ub_n   <= w_ub_n_n;
         mem_lb_n   <= w_lb_n_n;
      end
   end

endmodule

// File: tb/tb_huc_mem_ctrl.sv
// Bench for huc_mem_ctrl: table of directed reads plus hand sequences for
// write timing, write-during-read, read/write collision, reset mid-write and
// (when HUC_MEM_RDCACHE_EN is defined) cache hits.
module tb_huc_mem_ctrl;
   import huc_pkg::*;

   logic        clk;
   logic        rst;
   MemCtrl      req;
   logic [7:0]  dato;
   logic        busy;
   logic [21:0] mem_addr;
   logic [15:0] mem_dq_o, mem_dq_i;
   logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n;
   logic        load_mem;
   logic [15:0] mem [256];

   int n_checks = 0;
   int n_errors = 0;
   int cnt;

   typedef struct packed {
      logic [22:0] addr;
      logic [7:0]  dato;
      logic        ub_n;
      logic        lb_n;
      logic [21:0] maddr;
   } vec_t;

   vec_t vecs [6];

   huc_mem_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .dato      (dato),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_dq_o  (mem_dq_o),
      .mem_dq_i  (mem_dq_i),
      .mem_dq_oe (mem_dq_oe),
      .mem_ce_n  (mem_ce_n),
      .mem_oe_n  (mem_oe_n),
      .mem_we_n  (mem_we_n),
      .mem_ub_n  (mem_ub_n),
      .mem_lb_n  (mem_lb_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // external SRAM model: byte-lane writes while ce/we low, async read
   assign mem_dq_i = mem[mem_addr[7:0]];
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
         mem[1]    <= 16'hA55A;
         mem[2]    <= 16'h1234;
         mem[5]    <= 16'hBEEF;
         mem[8'h10] <= 16'h6655;
         mem[255]  <= 16'hC3E1;
      end else if (!mem_ce_n && !mem_we_n) begin
         if (!mem_lb_n) mem[mem_addr[7:0]][7:0]  <= mem_dq_o[7:0];
         if (!mem_ub_n) mem[mem_addr[7:0]][15:8] <= mem_dq_o[15:8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      req.oe = 1'b0;
      @(negedge clk);
      req.addr = v.addr; req.ce = 1'b1; req.ce2 = 1'b1; req.oe = 1'b1;
      repeat (2) @(negedge clk);
      chk("tbl_ub_n",  {31'd0, mem_ub_n}, {31'd0, v.ub_n});
      chk("tbl_lb_n",  {31'd0, mem_lb_n}, {31'd0, v.lb_n});
      chk("tbl_maddr", {10'd0, mem_addr}, {10'd0, v.maddr});
      repeat (4) @(negedge clk);
      chk("tbl_dato",  {24'd0, dato}, {24'd0, v.dato});
      chk("tbl_busy",  {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{addr: 23'h000004, dato: 8'h34, ub_n: 1'b1, lb_n: 1'b0, maddr: 22'h000002};
      vecs[1] = '{addr: 23'h000002, dato: 8'h5A, ub_n: 1'b1, lb_n: 1'b0, maddr: 22'h000001};
      vecs[2] = '{addr: 23'h000005, dato: 8'h12, ub_n: 1'b0, lb_n: 1'b1, maddr: 22'h000002};
      vecs[3] = '{addr: 23'h00000B, dato: 8'hBE, ub_n: 1'b0, lb_n: 1'b1, maddr: 22'h000005};
      vecs[4] = '{addr: 23'h00000A, dato: 8'hEF, ub_n: 1'b1, lb_n: 1'b0, maddr: 22'h000005};
      vecs[5] = '{addr: 23'h7FFFFF, dato: 8'hC3, ub_n: 1'b0, lb_n: 1'b1, maddr: 22'h3FFFFF};

      req = '0; rst = 1'b1; load_mem = 1'b1;
      repeat (3) @(negedge clk);
      load_mem = 1'b0;
      chk("rst_dato",    {24'd0, dato}, 32'hFF);
      chk("rst_busy",    {31'd0, busy}, 32'd0);
      chk("rst_maddr",   {10'd0, mem_addr}, 32'd0);
      chk("rst_dq_o",    {16'd0, mem_dq_o}, 32'd0);
      chk("rst_dq_oe",   {31'd0, mem_dq_oe}, 32'd0);
      chk("rst_strobes", {27'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1F);

      // first read: addr 3 -> word 1 high byte, 5 clocks after the trigger edge
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      req.ce = 1'b1; req.ce2 = 1'b1; req.oe = 1'b1; req.addr = 23'h000003;
      repeat (2) @(negedge clk);
      chk("rd1_ub_n",  {31'd0, mem_ub_n}, 32'd0);
      chk("rd1_lb_n",  {31'd0, mem_lb_n}, 32'd1);
      chk("rd1_ce_oe", {30'd0, mem_ce_n, mem_oe_n}, 32'd0);
      chk("rd1_maddr", {10'd0, mem_addr}, 32'd1);
      repeat (3) @(negedge clk);
      chk("rd1_dato_early", {24'd0, dato}, 32'hFF);
      chk("rd1_oe_n_last",  {31'd0, mem_oe_n}, 32'd0);
      @(negedge clk);
      chk("rd1_dato", {24'd0, dato}, 32'hA5);
      chk("rd1_oe_n_end", {31'd0, mem_oe_n}, 32'd1);
      chk("rd1_busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // write pulse: addr 0x10 data 0x3C, we_n low 4 clocks then 1 REC clock
      @(negedge clk);
      req.oe = 1'b0; req.we = 1'b1; req.addr = 23'h000010; req.dati = 8'h3C;
      cnt = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) req.we = 1'b0;
         if (!mem_we_n) cnt++;
         if (i == 2) begin
            chk("wr_maddr", {10'd0, mem_addr}, 32'h8);
            chk("wr_lb_ub", {30'd0, mem_lb_n, mem_ub_n}, 32'b01);
            chk("wr_dq_o",  {16'd0, mem_dq_o}, 32'h3C3C);
            chk("wr_dq_oe", {31'd0, mem_dq_oe}, 32'd1);
         end
         if (i == 6) begin
            chk("wr_rec_strobes", {29'd0, mem_ce_n, mem_we_n, mem_lb_n}, 32'b111);
            chk("wr_rec_dq_oe",   {31'd0, mem_dq_oe}, 32'd1);
         end
         if (i == 7) begin
            chk("wr_end_dq_oe", {31'd0, mem_dq_oe}, 32'd0);
            chk("wr_end_busy",  {31'd0, busy}, 32'd0);
         end
      end
      chk("wr_we_low_clks", cnt, 32'd4);
      chk("wr_mem8", {16'd0, mem[8]}, 32'h003C);

      // write pulse during an active read of addr 4
      @(negedge clk);
      req.oe = 1'b1; req.addr = 23'h000004;
      repeat (2) @(negedge clk);
      chk("wdr_rd_oe_n", {31'd0, mem_oe_n}, 32'd0);
      req.oe = 1'b0; req.we = 1'b1; req.addr = 23'h000011; req.dati = 8'h99;
      @(negedge clk);
      req.we = 1'b0;
      repeat (3) @(negedge clk);
      chk("wdr_dato", {24'd0, dato}, 32'h34);
      chk("wdr_busy_pend", {31'd0, busy}, 32'd1);
      chk("wdr_we_n_wait", {31'd0, mem_we_n}, 32'd1);
      @(negedge clk);
      chk("wdr_we_n", {31'd0, mem_we_n}, 32'd0);
      chk("wdr_ub_lb", {30'd0, mem_ub_n, mem_lb_n}, 32'b01);
      chk("wdr_dq_o", {16'd0, mem_dq_o}, 32'h9999);
      repeat (5) @(negedge clk);
      chk("wdr_busy_end", {31'd0, busy}, 32'd0);
      chk("wdr_mem8", {16'd0, mem[8]}, 32'h993C);

      // read rise and write pulse together in IDLE: write first, then read
      @(negedge clk);
      req.oe = 1'b1; req.we = 1'b1; req.addr = 23'h000011; req.dati = 8'h5A;
      @(negedge clk);
      req.we = 1'b0;
      @(negedge clk);
      chk("col_we_first", {30'd0, mem_we_n, mem_oe_n}, 32'b01);
      repeat (5) @(negedge clk);
      chk("col_gap_busy", {31'd0, busy}, 32'd1);
      chk("col_gap_ce_n", {31'd0, mem_ce_n}, 32'd1);
      @(negedge clk);
      chk("col_rd_after", {30'd0, mem_we_n, mem_oe_n}, 32'b10);
      repeat (4) @(negedge clk);
      chk("col_dato", {24'd0, dato}, 32'h5A);
      chk("col_busy", {31'd0, busy}, 32'd0);

      // reset two clocks into a write that also left a read pending
      @(negedge clk);
      req.oe = 1'b0;
      @(negedge clk);
      req.oe = 1'b1; req.we = 1'b1; req.addr = 23'h000012; req.dati = 8'h11;
      @(negedge clk);
      req.we = 1'b0;
      repeat (2) @(negedge clk);
      chk("rstw_in_wr", {31'd0, mem_we_n}, 32'd0);
      chk("rstw_busy",  {31'd0, busy}, 32'd1);
      rst = 1'b1; req.ce = 1'b0; req.ce2 = 1'b0; req.oe = 1'b0;
      @(negedge clk);
      chk("rstw_strobes", {27'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_ub_n, mem_lb_n}, 32'h1F);
      chk("rstw_dq_oe",   {31'd0, mem_dq_oe}, 32'd0);
      chk("rstw_busy0",   {31'd0, busy}, 32'd0);
      chk("rstw_dato",    {24'd0, dato}, 32'hFF);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (!mem_ce_n) cnt++;
      end
      chk("rstw_no_read", cnt, 32'd0);
      chk("rstw_idle_busy", {31'd0, busy}, 32'd0);

`ifdef HUC_MEM_RDCACHE_EN
      // cache: read 0x20 externally, then 0x21 hits in one clock
      @(negedge clk);
      req.ce = 1'b1; req.ce2 = 1'b1; req.oe = 1'b1; req.addr = 23'h000020;
      repeat (6) @(negedge clk);
      chk("c_rd20_dato", {24'd0, dato}, 32'h55);
      req.addr = 23'h000021;
      cnt = 0;
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      chk("c_hit_dato_early", {24'd0, dato}, 32'h55);
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      chk("c_hit_dato", {24'd0, dato}, 32'h66);
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      chk("c_hit_no_ce", cnt, 32'd0);
      chk("c_hit_busy", {31'd0, busy}, 32'd0);
      req.oe = 1'b0; req.we = 1'b1; req.addr = 23'h000021; req.dati = 8'h77;
      @(negedge clk);
      req.we = 1'b0;
      repeat (6) @(negedge clk);
      chk("c_wr_busy", {31'd0, busy}, 32'd0);
      req.oe = 1'b1;
      cnt = 0;
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      chk("c_upd_dato", {24'd0, dato}, 32'h77);
      @(negedge clk);
      if (!mem_ce_n) cnt++;
      chk("c_upd_no_ce", cnt, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/huc_mem_ctrl.md
# huc_mem_ctrl

Memory-side responder for the cartridge `MemCtrl` channel that mappers drive toward ROM/RAM. It turns the mapper's level-style `ce`/`oe`/`we` requests into timed cycles on an external asynchronous 16-bit SRAM/PSRAM. It returns byte read data on `dato`. One instance serves the ROM channel and a second instance serves the RAM channel.

## Interface
Parameters:
- `RD_CYC`, 4: clocks from strobe assertion to data sample; legal range 2..15.
- `WR_CYC`, 4: clocks `mem_we_n` is held low; legal range 2..15.
- `ADDR_W`, 22: external word-address width.

Ports:
- `clk`  in  1  system clock; the design has one clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  MemCtrl  mapper request: `addr[22:0]`, `dati[7:0]`, `ce`, `ce2`, `oe`, `we`.
- `dato`  out  8  read data, registered.
- `busy`  out  1  an external access is in progress or a write is pending.
- `mem_addr`  out  ADDR_W  word address, equal to `req.addr[ADDR_W:1]`.
- `mem_dq_o` / `mem_dq_i`  out/in  16  data bus, out and in.
- `mem_dq_oe`  out  1  data bus output enable.
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`, `mem_ub_n`, `mem_lb_n`  out  1 each  active-low strobes.

## Operation
- Active request: `act = req.ce & req.ce2`.
- Read trigger: a rising edge of `act & req.oe`, or a change of `req.addr` while `act & req.oe` stays high.
- Write trigger: `act & req.we`. `we` is a single-cycle synchronous pulse. `addr` and `dati` are captured in the cycle the pulse occurs.
- Byte lane: `addr[0]=0` selects the low byte (`mem_lb_n`); `addr[0]=1` selects the high byte (`mem_ub_n`).
- Writes drive the captured byte on both halves of `mem_dq_o`.
- FSM states: IDLE, RD, WR, REC.
  - IDLE→WR if a write is pending; pending writes take priority.
  - IDLE→RD if a read trigger or a read pending flag is set.
  - RD→IDLE after `RD_CYC` clocks; the selected byte is sampled into `dato` on the last cycle.
  - WR→REC after `WR_CYC` clocks.
  - REC→IDLE after 1 clock, with all strobes high.
- A one-entry write-pending register holds a write trigger that arrives during RD, WR or REC.
  - If a second write arrives while the entry is full, it overwrites the entry (last wins). This is documented mapper misuse.
- A read-pending flag latches a read trigger that arrives when not in IDLE. The flag re-reads the current `req.addr` when it is serviced.
- `dato` holds its last value between reads. It is never driven from a write.
- `busy = (state != IDLE) | wr_pend | rd_pend`.

## Timing
- Reset values: `dato=8'hFF`, `busy=0`, `mem_addr=0`, `mem_dq_o=0`, `mem_dq_oe=0`, all `_n` strobes `=1`.
- Reset mid-access: strobes are high at the first edge with `rst`. Pending write and read are discarded. State returns to IDLE.
- Read latency: the trigger is seen at edge T0, strobes go low at T1, and `dato` is valid after edge T0+1+`RD_CYC`. With the default, that is 5 clocks.
- Write: `mem_dq_oe` and data are asserted from T1 through the REC cycle. `mem_we_n` is low for `WR_CYC` clocks, then REC with `mem_dq_oe` still high. Total occupancy is `WR_CYC+1` clocks.
- Address and lane selects are held stable for the whole RD or WR state and are registered at T1.
- A read trigger and a write trigger in the same cycle in IDLE: the write executes first, then the read.

## Configuration
- `HUC_MEM_RDCACHE_EN` defined: a one-word read cache holds a tag (`addr[22:1]`), 16-bit data and a valid bit.
  - A read trigger whose tag matches while valid updates `dato` at the next edge and never leaves IDLE.
  - A write to the cached word updates the matching byte of the cache.
  - Reset clears valid.
- Macro undefined: every read performs an external RD cycle.

## Structure
- Shared package `huc_pkg`:
  - holds the existing `MemCtrl` typedef;
  - adds an `HucMemSt` enum (IDLE, RD, WR, REC);
  - adds `HUC_MEM_DATO_RST = 8'hFF`.
- Sub-module `huc_mem_cache`: the tag/data/valid store compiled under `HUC_MEM_RDCACHE_EN`. Inputs are lookup address, fill word and write-byte update. Outputs are hit and data.

## Test plan
- Reset, then hold `ce=ce2=oe=1`, `addr=0x000003`, `mem_dq_i=0xA55A`:
  - `mem_ub_n=0` at T1;
  - `dato=0xA5` after 5 clocks;
  - `busy` low afterward.
- Write pulse `addr=0x000010`, `dati=0x3C`:
  - `mem_addr=0x8` and `mem_lb_n=0`;
  - `mem_we_n` low for exactly 4 clocks, then 1 REC clock.
- Write pulse arrives during an active read: the read completes with the correct `dato`, then the write executes with the captured data.
- Simultaneous read rise and write pulse in IDLE: WR strobes are seen first, then RD, and `dato` reflects the post-write memory model.
- Assert `rst` two clocks into a WR cycle: all strobes are high and `mem_dq_oe=0` at the next edge, and the pending read is dropped.
- With `HUC_MEM_RDCACHE_EN` defined, read `0x20`, then `0x21`:
  - the second read yields `dato` in 1 clock with no `mem_ce_n` activity;
  - write `0x21`=`0x77`, then re-read `0x21` gives `0x77` from the cache.
